// File: rtl/config_mem_unit.sv
// Configuration memory stage: captures a config word on a write_en rising edge,
// validates it, commits it to a persistent register and rotates the system key.
module config_mem_unit #(
  parameter logic [1:0] KEY_INIT = 2'b10,
  parameter int         CNT_W    = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             write_en,
  input  logic [34:0]      configin,
  output logic [1:0]       syskey,
  output logic [34:0]      config_q,
  output logic             valid,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] commit_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CHECK  = 2'b01,
    COMMIT = 2'b10,
    HOLD   = 2'b11
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        write_en_d;
  logic [34:0] shadow;
  logic        write_evt;
  logic        word_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign write_evt = write_en & ~write_en_d;
  assign word_ok   = (shadow[34:32] != 3'b111) && (shadow[15:0] != 16'h0000);
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (write_evt) state_d = CHECK;
      CHECK:   state_d = word_ok ? COMMIT : HOLD;
      COMMIT:  state_d = HOLD;
      HOLD:    if (!write_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q    <= IDLE;
      write_en_d <= 1'b0;
      shadow     <= '0;
      config_q   <= '0;
      valid      <= 1'b0;
      err        <= 1'b0;
      commit_cnt <= '0;
      syskey     <= KEY_INIT;
    end else begin
      state_q    <= state_d;
      write_en_d <= write_en;
      case (state_q)
        IDLE: begin
          if (write_evt) begin
            shadow <= configin;
            err    <= 1'b0;
          end
        end
        CHECK: begin
          if (!word_ok) err <= 1'b1;
        end
        // commit stage: key rotation makes the current password single-use
        COMMIT: begin
          config_q   <= shadow;
          valid      <= 1'b1;
          commit_cnt <= sat_inc(commit_cnt);
          syskey     <= syskey + 2'b01;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_config_mem_unit.sv
// Scoreboard bench for config_mem_unit; a second instance with CNT_W=2 shares
// the stimulus to observe counter saturation.
module tb_config_mem_unit;

  logic        clk;
  logic        arst;
  logic        write_en;
  logic [34:0] configin;

  logic [1:0]  syskey, syskey2;
  logic [34:0] config_q, config_q2;
  logic        valid, valid2, busy, busy2, err, err2;
  logic [7:0]  commit_cnt;
  logic [1:0]  commit_cnt2;
  logic [1:0]  dbg_state, dbg_state2;

  config_mem_unit #(.KEY_INIT(2'b10), .CNT_W(8)) dut (
    .clk(clk), .arst(arst), .write_en(write_en), .configin(configin),
    .syskey(syskey), .config_q(config_q), .valid(valid), .busy(busy),
    .err(err), .commit_cnt(commit_cnt), .dbg_state(dbg_state)
  );

  config_mem_unit #(.KEY_INIT(2'b10), .CNT_W(2)) dut2 (
    .clk(clk), .arst(arst), .write_en(write_en), .configin(configin),
    .syskey(syskey2), .config_q(config_q2), .valid(valid2), .busy(busy2),
    .err(err2), .commit_cnt(commit_cnt2), .dbg_state(dbg_state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [34:0] cfg;
    logic [1:0]  key;
    logic [7:0]  cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  logic [1:0]  m_key;
  logic [7:0]  m_cnt;
  logic [1:0]  m_cnt2;
  logic [34:0] m_cfg;

  task automatic model_reset();
    m_key  = 2'b10;
    m_cnt  = 8'd0;
    m_cnt2 = 2'd0;
    m_cfg  = 35'd0;
    sbq.delete();
  endtask

  task automatic test_reset();
    arst = 1'b1;
    write_en = 1'b0;
    configin = 35'd0;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    total++;
    if (syskey !== 2'b10) begin bad++; $display("FAIL reset_syskey got=%b want=10", syskey); end
    total++;
    if (config_q !== 35'd0) begin bad++; $display("FAIL reset_config_q got=%h want=0", config_q); end
    total++;
    if (valid !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_valid_err got=%b%b want=00", valid, err); end
    total++;
    if (commit_cnt !== 8'd0 || commit_cnt2 !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", commit_cnt, commit_cnt2); end
    total++;
    if (busy !== 1'b0 || dbg_state !== 2'b00) begin bad++; $display("FAIL reset_state got busy=%b st=%b want 0/00", busy, dbg_state); end
  endtask

  // Called at a negedge; write_en is sampled high on nhigh consecutive edges E0..
  task automatic do_write(input logic [34:0] cfg, input int nhigh);
    logic        ok;
    int          idle_e;
    logic [63:0] junk;
    exp_t        e;
    ok = (cfg[34:32] != 3'b111) && (cfg[15:0] != 16'h0000);
    write_en = 1'b1;
    configin = cfg;
    if (ok) begin
      m_key  = m_key + 2'b01;
      m_cnt  = (m_cnt == 8'hFF) ? m_cnt : m_cnt + 8'd1;
      m_cnt2 = (m_cnt2 == 2'b11) ? m_cnt2 : m_cnt2 + 2'd1;
      m_cfg  = cfg;
      e.cfg = cfg; e.key = m_key; e.cnt = m_cnt; e.cnt2 = m_cnt2;
      sbq.push_back(e);
    end
    idle_e = ok ? ((nhigh > 3) ? nhigh : 3) : ((nhigh > 2) ? nhigh : 2);
    for (int k = 0; k <= idle_e; k++) begin
      @(negedge clk);
      junk = {$urandom, $urandom};
      configin = junk[34:0];
      if (k == nhigh - 1) write_en = 1'b0;
      total++;
      if (busy !== (k < idle_e)) begin bad++; $display("FAIL busy_e%0d got=%b want=%b", k, busy, (k < idle_e)); end
      if (k == 0) begin
        total++;
        if (dbg_state !== 2'b01 || err !== 1'b0) begin bad++; $display("FAIL capture got st=%b err=%b want 01/0", dbg_state, err); end
      end
      if (k == 1) begin
        total++;
        if (dbg_state !== (ok ? 2'b10 : 2'b11) || err !== !ok) begin
          bad++; $display("FAIL check got st=%b err=%b want %b/%b", dbg_state, err, (ok ? 2'b10 : 2'b11), !ok);
        end
      end
      if (k == 2) begin
        if (ok) begin
          if (sbq.size() == 0) begin
            total++; bad++; $display("FAIL scoreboard_empty got=0 want=1 entries");
          end else begin
            e = sbq.pop_front();
            total++;
            if (config_q !== e.cfg || valid !== 1'b1) begin bad++; $display("FAIL commit_cfg got=%h v=%b want=%h v=1", config_q, valid, e.cfg); end
            total++;
            if (syskey !== e.key || syskey2 !== e.key) begin bad++; $display("FAIL commit_key got=%b/%b want=%b", syskey, syskey2, e.key); end
            total++;
            if (commit_cnt !== e.cnt || commit_cnt2 !== e.cnt2) begin bad++; $display("FAIL commit_cnt got=%0d/%0d want=%0d/%0d", commit_cnt, commit_cnt2, e.cnt, e.cnt2); end
          end
        end else begin
          total++;
          if (config_q !== m_cfg || syskey !== m_key || commit_cnt !== m_cnt || err !== 1'b1) begin
            bad++; $display("FAIL reject got cfg=%h key=%b cnt=%0d err=%b want cfg=%h key=%b cnt=%0d err=1", config_q, syskey, commit_cnt, err, m_cfg, m_key, m_cnt);
          end
        end
      end
    end
  endtask

  task automatic test_hold_long();
    do_write(35'h0_1234_0010, 10);
    total++;
    if (config_q !== 35'h0_1234_0010 || syskey !== 2'b11 || commit_cnt !== 8'd1) begin
      bad++; $display("FAIL single_commit got cfg=%h key=%b cnt=%0d want 012340010/11/1", config_q, syskey, commit_cnt);
    end
  endtask

  task automatic test_invalid();
    do_write(35'h7_0000_0005, 2);
    do_write(35'h1_5555_0000, 1);
    do_write(35'h2_00AA_0003, 2);
    total++;
    if (err !== 1'b0 || config_q !== 35'h2_00AA_0003) begin bad++; $display("FAIL recover got err=%b cfg=%h want 0/200aa0003", err, config_q); end
  endtask

  task automatic test_back_to_back();
    do_write(35'h3_0F0F_0101, 2);
    do_write(35'h4_F0F0_0202, 2);
  endtask

  task automatic test_reset_in_commit();
    write_en = 1'b1;
    configin = 35'h5_ABCD_0077;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (dbg_state !== 2'b10) begin bad++; $display("FAIL pre_abort_state got=%b want=10", dbg_state); end
    arst = 1'b1;
    write_en = 1'b0;
    @(negedge clk);
    total++;
    if (config_q !== 35'd0 || valid !== 1'b0 || syskey !== 2'b10 || commit_cnt !== 8'd0 ||
        busy !== 1'b0 || err !== 1'b0 || dbg_state !== 2'b00) begin
      bad++; $display("FAIL abort got cfg=%h v=%b key=%b cnt=%0d busy=%b err=%b st=%b want all reset", config_q, valid, syskey, commit_cnt, busy, err, dbg_state);
    end
    arst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_wrap();
    test_reset();
    for (int i = 0; i < 4; i++) do_write({3'd1, 16'(i), 16'(i + 1)}, 2);
    total++;
    if (syskey !== 2'b10 || commit_cnt !== 8'd4) begin bad++; $display("FAIL wrap got key=%b cnt=%0d want 10/4", syskey, commit_cnt); end
  endtask

  task automatic test_saturation();
    test_reset();
    for (int i = 0; i < 5; i++) do_write({3'd2, 16'(i * 3), 16'(i + 9)}, 2);
    total++;
    if (commit_cnt2 !== 2'b11 || commit_cnt !== 8'd5 || syskey2 !== 2'b11) begin
      bad++; $display("FAIL saturate got cnt2=%0d cnt=%0d key2=%b want 3/5/11", commit_cnt2, commit_cnt, syskey2);
    end
  endtask

  initial begin
    arst = 1'b1;
    write_en = 1'b0;
    configin = 35'd0;
    model_reset();
    test_reset();
    test_hold_long();
    test_invalid();
    test_back_to_back();
    test_reset_in_commit();
    test_wrap();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/config_mem_unit.md
# config_mem_unit

Configuration memory stage directly downstream of the access-control FSM. It accepts the 35-bit configuration word and write enable that the controller drives while in its STORE state, and validates the word before committing it to a persistent register. It also supplies the 2-bit system key the controller compares against the user password, and rotates that key after every successful commit so a password is single-use.

## Interface
Parameters:
- KEY_INIT, 2'b10, system key value after reset
- CNT_W, 8, width of the commit counter

Ports:
- clk  in  1  clock, posedge
- arst  in  1  reset, synchronous, active-high; sampled only on posedge clk
- write_en  in  1  write request from controller; level, may stay high for many cycles
- configin  in  35  configuration word from controller; fields: [34:32] mode, [31:16] threshold, [15:0] period
- syskey  out  2  current system key, registered
- config_q  out  35  last committed configuration, registered
- valid  out  1  config_q holds a committed word
- busy  out  1  high in any state other than IDLE
- err  out  1  last captured word failed validation (sticky)
- commit_cnt  out  CNT_W  number of successful commits, saturating
- dbg_state  out  2  current FSM state

## Operation
- Write detection: register write_en_d <= write_en every cycle. A write event is write_en & ~write_en_d, i.e. a rising edge. A level held high produces exactly one event.
- FSM states (encoding): IDLE=2'b00, CHECK=2'b01, COMMIT=2'b10, HOLD=2'b11.
- IDLE:
  - On a write event, load shadow <= configin, clear err, and go to CHECK.
  - Otherwise stay in IDLE.
- CHECK: the word is valid iff mode != 3'b111 and period != 16'h0000.
  - If valid, go to COMMIT.
  - If invalid, set err=1 and go to HOLD. config_q, valid, syskey and commit_cnt are unchanged.
- COMMIT:
  - config_q <= shadow and valid <= 1.
  - commit_cnt <= commit_cnt+1, saturating at all-ones.
  - syskey <= syskey+1 mod 4, so 2'b11 wraps to 2'b00.
  - Go to HOLD.
- HOLD: stay until write_en==0, then go to IDLE. This blocks a second commit from one long STORE dwell.
- configin is sampled only on the capture cycle. Changes to it in CHECK, COMMIT or HOLD have no effect.
- A write event arising while busy is ignored. A new capture is possible only from IDLE.
- Reset values:
  - syskey=KEY_INIT
  - config_q=0, valid=0, err=0, commit_cnt=0
  - busy=0, dbg_state=IDLE
  - shadow=0, write_en_d=0
- Reset has priority over every state and every input, and takes effect mid-operation too. A reset in CHECK or COMMIT aborts with no commit and no key rotation.
- If write_en is already high at the first edge after reset, write_en_d=0 makes it a write event and a capture occurs.

## Timing
- Edge E0 samples the write event: shadow is loaded and the state becomes CHECK. busy=1 after E0.
- Edge E1 performs validation:
  - State becomes COMMIT or HOLD.
  - err is visible after E1 on the fail path.
- Edge E2 commits:
  - config_q, valid, commit_cnt and syskey update and are visible after E2.
  - State becomes HOLD.
- Minimum HOLD residence is 1 cycle. IDLE is re-entered on the first edge that samples write_en==0.
- Fastest back-to-back commit:
  - write_en high at E0, low at E2, high again at E4.
  - Second capture at E4, second commit visible after E6.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- The controller sees the rotated syskey from the cycle after E2. Its next password check must use the new key.

## Test plan
- Reset, then idle 5 cycles -> syskey=2'b10, config_q=0, valid=0, err=0, commit_cnt=0, busy=0, dbg_state=00.
- write_en rises with configin=35'h0_1234_0010 (mode 0, period 16'h0010) and is held 10 cycles -> exactly one commit:
  - config_q=35'h0_1234_0010 after E2, valid=1, commit_cnt=1, syskey=2'b11.
  - busy stays high until the cycle after write_en falls.
- Capture a word with mode=3'b111, then one with period=0 -> err=1 after E1 each time; config_q, syskey and commit_cnt are unchanged. A following valid word clears err at capture and commits.
- Four valid commits from reset -> syskey sequence 10, 11, 00, 01, 10 (wrap checked); commit_cnt=4.
- Assert arst at the edge where the state is COMMIT -> no commit occurs; every output reads its reset value on the next cycle.
- With CNT_W=2, perform 5 valid commits -> commit_cnt saturates at 2'b11; syskey keeps rotating.
